idu_stage: RTL and testbench
============================

// Module: idu_stage
// PURPOSE
//  Registered, parametrised decode stage between IFU and EXU. Decodes RV32I (+M when HAS_M) and generates sign-extended immediates.
//  Flags ebreak/illegal. valid/ready on both sides; 2-entry skid buffer gives 1 inst/cycle with registered in_ready; flush kills in-flight entries.
// PARAMETERS
//  XLEN   32  datapath/pc/immediate width (32 or 64; imm sign-extended to XLEN)
//  HAS_M  1   1: decode funct7=0000001 OP as M ops; 0: those encodings flag illegal
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     async active-low reset
//  flush        in   1     drop all buffered/incoming instructions this cycle
//  in_valid     in   1     IFU has instruction
//  in_ready     out  1     stage can accept (registered: !skid_full)
//  in_inst      in   32    instruction word
//  in_pc        in   XLEN  instruction pc
//  out_valid    out  1     decoded bundle valid
//  out_ready    in   1     EXU accepts bundle
//  out_pc       out  XLEN  pc of bundle
//  out_rs1/rs2/rd out 5    inst[19:15]/[24:20]/[11:7]; forced 0 when format lacks field
//  out_funct3   out  3     inst[14:12]
//  out_imm      out  XLEN  I/S/B/U/J immediate, sign-extended; 0 for R-type
//  out_alu_op   out  5     ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 MUL10 MULH11 MULHSU12 MULHU13 DIV14 DIVU15 REM16 REMU17
//  out_ctrl     out  11    [0]mem_rd [1]mem_wr [2]reg_wr [3]branch [4]jal [5]jalr [6]lui [7]auipc [8]use_imm [9]ebreak [10]illegal
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, in_ready=1, all out_* data/ctrl=0, skid empty. Release takes effect next clk edge.
//  Decode combinational on in_inst, captured at accept (in_valid&in_ready); latency 1 cycle accept->out_valid.
//  States: EMPTY(out_valid=0), ONE(out reg full), TWO(out+skid full, in_ready=0).
//   EMPTY: accept->ONE.  ONE: accept&!pop->TWO (to skid); pop&!accept->EMPTY; accept&pop->ONE with new bundle.
//   TWO: pop->ONE, skid moves to out reg; no accept possible. pop=out_valid&out_ready.
//  Order strictly FIFO; bundle held stable while out_valid&!out_ready.
//  flush: next state EMPTY, in_ready=1; same-cycle accept discarded; flush has priority over pop/accept.
//  alu_op: OP uses {funct7,funct3}; M selected only when funct7==0000001 (checked before base ops).
//   OP-IMM: funct3 map as OP, SRAI when inst[30]=1; LOAD/STORE/JAL/JALR/LUI/AUIPC/BRANCH -> ADD.
//  reg_wr = R|I|U|J types and not illegal and rd!=0; use_imm = non-R formats.
//  ebreak: inst==0x00100073 -> ctrl[9]=1, reg_wr=0. ecall/fence/csr: illegal=0, all other ctrl 0.
//  illegal: unknown opcode, inst[1:0]!=11, OP funct7 not in {0000000,0100000(funct3 000/101 only),0000001&HAS_M},
//   shift-imm with bad funct7 (XLEN=32: inst[31:25] not 0000000/0100000); illegal -> ctrl=only bit10, alu_op=0.
//  XLEN=64: shamt uses inst[25:20]; imm sign bit inst[31] replicated to bit 63.
// TESTING
//  1 addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, alu_op=0, ctrl=0x104, rd=1.
//  2 Back-to-back 4 insts, out_ready low 3 cycles -> in_ready=0 after 2nd accepted, no loss, order kept, out stable.
//  3 mul x3,x1,x2 (0x022081B3): HAS_M=1 -> alu_op=10 ctrl[2]=1; HAS_M=0 -> ctrl=0x400.
//  4 beq offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, ctrl[3]=1, ctrl[8]=1, rd=0, reg_wr=0.
//  5 TWO state + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed inst never emitted.
//  6 rst_n low mid-stall (TWO) -> outputs 0 immediately; 0x00100073 after release -> ctrl=0x300? no: ctrl=0x200.

Source files
------------

// File: rtl/idu_stage.sv
// Decode stage between IFU and EXU: combinational RV32I(+M) decode feeding a
// two-entry output/skid buffer with valid/ready handshakes on both sides.
module idu_stage #(
  parameter int unsigned XLEN  = 32,
  parameter bit          HAS_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic [10:0]     out_ctrl
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int unsigned CT_MEM_RD  = 0;
  localparam int unsigned CT_MEM_WR  = 1;
  localparam int unsigned CT_REG_WR  = 2;
  localparam int unsigned CT_BRANCH  = 3;
  localparam int unsigned CT_JAL     = 4;
  localparam int unsigned CT_JALR    = 5;
  localparam int unsigned CT_LUI     = 6;
  localparam int unsigned CT_AUIPC   = 7;
  localparam int unsigned CT_USE_IMM = 8;
  localparam int unsigned CT_EBREAK  = 9;
  localparam int unsigned CT_ILLEGAL = 10;

  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_MUL = 5'd10;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic [10:0]     ctrl;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t          state, state_nx;
  bundle_t         dec, out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic            accept, pop, ld_out_in, ld_out_skid, ld_skid;

  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return 5'd0;  // ADD
      3'b001:  return 5'd2;  // SLL
      3'b010:  return 5'd3;  // SLT
      3'b011:  return 5'd4;  // SLTU
      3'b100:  return 5'd5;  // XOR
      3'b101:  return 5'd6;  // SRL
      3'b110:  return 5'd8;  // OR
      default: return 5'd9;  // AND
    endcase
  endfunction

  logic [6:0]  opc, f7, shift_hi;
  logic [2:0]  f3;
  logic        f_r, f_i, f_s, f_b, f_u, f_j, illegal;
  logic [31:0] imm32;

  // Combinational decode of the incoming instruction word
  always_comb begin
    opc      = in_inst[6:0];
    f3       = in_inst[14:12];
    f7       = in_inst[31:25];
    // RV64 shamt is 6 bits, so inst[25] belongs to the shift amount there
    shift_hi = (XLEN == 64) ? {in_inst[31:26], 1'b0} : in_inst[31:25];
    f_r = 1'b0; f_i = 1'b0; f_s = 1'b0; f_b = 1'b0; f_u = 1'b0; f_j = 1'b0;
    illegal = 1'b0;
    imm32   = '0;
    dec     = '0;
    dec.funct3 = f3;
    if (in_inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OPC_LUI:    begin f_u = 1'b1; dec.ctrl[CT_LUI]   = 1'b1; end
        OPC_AUIPC:  begin f_u = 1'b1; dec.ctrl[CT_AUIPC] = 1'b1; end
        OPC_JAL:    begin f_j = 1'b1; dec.ctrl[CT_JAL]   = 1'b1; end
        OPC_JALR:   begin f_i = 1'b1; dec.ctrl[CT_JALR]  = 1'b1; end
        OPC_BRANCH: begin f_b = 1'b1; dec.ctrl[CT_BRANCH] = 1'b1; end
        OPC_LOAD:   begin f_i = 1'b1; dec.ctrl[CT_MEM_RD] = 1'b1; end
        OPC_STORE:  begin f_s = 1'b1; dec.ctrl[CT_MEM_WR] = 1'b1; end
        OPC_OPIMM: begin
          f_i = 1'b1;
          dec.alu_op = base_alu(f3);
          if (f3 == 3'b001 && shift_hi != 7'b0000000) illegal = 1'b1;
          if (f3 == 3'b101) begin
            if (shift_hi == 7'b0100000)      dec.alu_op = ALU_SRA;
            else if (shift_hi != 7'b0000000) illegal = 1'b1;
          end
        end
        OPC_OP: begin
          f_r = 1'b1;
          if (f7 == 7'b0000001) begin
            if (HAS_M) dec.alu_op = ALU_MUL + {2'b00, f3};
            else       illegal = 1'b1;
          end else if (f7 == 7'b0000000) begin
            dec.alu_op = base_alu(f3);
          end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
            dec.alu_op = ALU_SUB;
          end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
            dec.alu_op = ALU_SRA;
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_SYSTEM: dec.ctrl[CT_EBREAK] = (in_inst == 32'h0010_0073);
        OPC_FENCE:  ;
        default:    illegal = 1'b1;
      endcase
    end

    if (f_i)      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (f_s) imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (f_b) imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (f_u) imm32 = {in_inst[31:12], 12'b0};
    else if (f_j) imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    dec.imm        = {XLEN{imm32[31]}};
    dec.imm[31:0]  = imm32;

    dec.rs1 = (f_r | f_i | f_s | f_b) ? in_inst[19:15] : 5'd0;
    dec.rs2 = (f_r | f_s | f_b)       ? in_inst[24:20] : 5'd0;
    dec.rd  = (f_r | f_i | f_u | f_j) ? in_inst[11:7]  : 5'd0;
    dec.ctrl[CT_USE_IMM] = f_i | f_s | f_b | f_u | f_j;
    dec.ctrl[CT_REG_WR]  = (f_r | f_i | f_u | f_j) && (in_inst[11:7] != 5'd0);

    if (illegal) begin
      dec        = '0;
      dec.funct3 = f3;
      dec.ctrl[CT_ILLEGAL] = 1'b1;
    end
  end

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != S_EMPTY);
  assign in_ready  = (state != S_TWO);

  // Next-state and buffer load selection; flush overrides pop and accept
  always_comb begin
    state_nx    = state;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin state_nx = S_ONE; ld_out_in = 1'b1; end
        S_ONE: begin
          if (accept && !pop)      begin state_nx = S_TWO; ld_skid = 1'b1; end
          else if (pop && !accept) state_nx = S_EMPTY;
          else if (pop && accept)  ld_out_in = 1'b1;
        end
        S_TWO:   if (pop) begin state_nx = S_ONE; ld_out_skid = 1'b1; end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nx;
  end

  // Output and skid bundle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_pc_q  <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      if (ld_out_in) begin
        out_q    <= dec;
        out_pc_q <= in_pc;
      end else if (ld_out_skid) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc_q;
      end
      if (ld_skid) begin
        skid_q    <= dec;
        skid_pc_q <= in_pc;
      end
    end
  end

  assign out_pc     = out_pc_q;
  assign out_rs1    = out_q.rs1;
  assign out_rs2    = out_q.rs2;
  assign out_rd     = out_q.rd;
  assign out_funct3 = out_q.funct3;
  assign out_imm    = out_q.imm;
  assign out_alu_op = out_q.alu_op;
  assign out_ctrl   = out_q.ctrl;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: fixed vectors, handshake corner sequences, and a
// randomized run against a queue-based reference model.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid, nm_in_ready, nm_out_valid;
  logic [31:0] out_pc, out_imm, nm_out_pc, nm_out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic [4:0]  nm_rs1, nm_rs2, nm_rd, nm_alu_op;
  logic [2:0]  out_funct3, nm_funct3;
  logic [10:0] out_ctrl, nm_ctrl;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .HAS_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_ctrl(out_ctrl));

  idu_stage #(.XLEN(32), .HAS_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_pc(nm_out_pc), .out_rs1(nm_rs1), .out_rs2(nm_rs2), .out_rd(nm_rd),
    .out_funct3(nm_funct3), .out_imm(nm_out_imm), .out_alu_op(nm_alu_op), .out_ctrl(nm_ctrl));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [10:0] ctrl;
    logic [10:0] ctrl_nm;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [10:0] ctrl;
  } exp_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[16];
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input exp_t e);
    chk({name, "_pc"},     64'(out_pc),     64'(e.pc));
    chk({name, "_rs1"},    64'(out_rs1),    64'(e.rs1));
    chk({name, "_rs2"},    64'(out_rs2),    64'(e.rs2));
    chk({name, "_rd"},     64'(out_rd),     64'(e.rd));
    chk({name, "_funct3"}, 64'(out_funct3), 64'(e.funct3));
    chk({name, "_imm"},    64'(out_imm),    64'(e.imm));
    chk({name, "_alu"},    64'(out_alu_op), 64'(e.alu));
    chk({name, "_ctrl"},   64'(out_ctrl),   64'(e.ctrl));
  endtask

  // Reference decode from the ISA field rules (HAS_M=1, XLEN=32)
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    byte  fmt;
    bit   ill;
    int   imm;
    int   base_map[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    e = '{default: '0};
    e.funct3 = f3;
    fmt = "N";
    ill = 1'b0;
    if (w[1:0] != 2'b11) ill = 1'b1;
    else case (w[6:0])
      7'h37: begin fmt = "U"; e.ctrl[6] = 1'b1; end
      7'h17: begin fmt = "U"; e.ctrl[7] = 1'b1; end
      7'h6F: begin fmt = "J"; e.ctrl[4] = 1'b1; end
      7'h67: begin fmt = "I"; e.ctrl[5] = 1'b1; end
      7'h63: begin fmt = "B"; e.ctrl[3] = 1'b1; end
      7'h03: begin fmt = "I"; e.ctrl[0] = 1'b1; end
      7'h23: begin fmt = "S"; e.ctrl[1] = 1'b1; end
      7'h13: begin
        fmt = "I";
        e.alu = 5'(base_map[f3]);
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'd7;
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
      7'h33: begin
        fmt = "R";
        if (f7 == 7'h01) e.alu = 5'(10 + int'(f3));
        else if (f7 == 7'h00) e.alu = 5'(base_map[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd7;
        else ill = 1'b1;
      end
      7'h73: if (w == 32'h0010_0073) e.ctrl[9] = 1'b1;
      7'h0F: ;
      default: ill = 1'b1;
    endcase
    case (fmt)
      "I": imm = $signed(w) >>> 20;
      "S": imm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      "B": imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      "U": imm = int'(w & 32'hFFFF_F000);
      "J": imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default: imm = 0;
    endcase
    e.imm = 32'(imm);
    if (fmt inside {"R", "I", "S", "B"}) e.rs1 = w[19:15];
    if (fmt inside {"R", "S", "B"})      e.rs2 = w[24:20];
    if (fmt inside {"R", "I", "U", "J"}) e.rd  = w[11:7];
    e.ctrl[8] = fmt inside {"I", "S", "B", "U", "J"};
    e.ctrl[2] = (fmt inside {"R", "I", "U", "J"}) && (w[11:7] != 5'd0);
    if (ill) begin
      e = '{default: '0};
      e.funct3 = f3;
      e.ctrl = 11'h400;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'h0000_0013; in_pc = '0;
  endtask

  // Two back-to-back accepts with EXU stalled: leaves the stage holding two bundles
  task automatic fill_two();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; in_inst = 32'h0010_0093; in_pc = 32'h1000;
    @(negedge clk);
    in_inst = 32'h0020_0113; in_pc = 32'h1004;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got[$];
    logic [31:0] seq_inst[4];
    int idx;
    bit will_acc, will_pop;
    exp_t e;

    tbl[0]  = '{32'hFFF0_0093, 32'hFFFF_FFFF, 5'd0,  11'h104, 11'h104, 5'd1};
    tbl[1]  = '{32'h0220_81B3, 32'h0000_0000, 5'd10, 11'h004, 11'h400, 5'd3};
    tbl[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 5'd0,  11'h108, 11'h108, 5'd0};
    tbl[3]  = '{32'h0010_0073, 32'h0000_0000, 5'd0,  11'h200, 11'h200, 5'd0};
    tbl[4]  = '{32'h4073_02B3, 32'h0000_0000, 5'd1,  11'h004, 11'h004, 5'd5};
    tbl[5]  = '{32'h4031_5093, 32'h0000_0403, 5'd7,  11'h104, 11'h104, 5'd1};
    tbl[6]  = '{32'h1234_5137, 32'h1234_5000, 5'd0,  11'h144, 11'h144, 5'd2};
    tbl[7]  = '{32'h0020_A423, 32'h0000_0008, 5'd0,  11'h102, 11'h102, 5'd0};
    tbl[8]  = '{32'hFF9F_F0EF, 32'hFFFF_FFF8, 5'd0,  11'h114, 11'h114, 5'd1};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 5'd0,  11'h400, 11'h400, 5'd0};
    tbl[10] = '{32'h2000_0033, 32'h0000_0000, 5'd0,  11'h400, 11'h400, 5'd0};
    tbl[11] = '{32'h4000_1033, 32'h0000_0000, 5'd0,  11'h400, 11'h400, 5'd0};
    tbl[12] = '{32'h4000_1093, 32'h0000_0000, 5'd0,  11'h400, 11'h400, 5'd0};
    tbl[13] = '{32'h0000_0013, 32'h0000_0000, 5'd0,  11'h100, 11'h100, 5'd0};
    tbl[14] = '{32'hFFC1_2183, 32'hFFFF_FFFC, 5'd0,  11'h105, 11'h105, 5'd3};
    tbl[15] = '{32'h0000_0073, 32'h0000_0000, 5'd0,  11'h000, 11'h000, 5'd0};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_ctrl",      64'(out_ctrl),  64'd0);
    chk("reset_imm",       64'(out_imm),   64'd0);
    chk("reset_pc",        64'(out_pc),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-instruction vectors through an otherwise empty stage
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_inst = tbl[i].inst; in_pc = 32'h400 + 32'(i * 4);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(32'h400 + 32'(i * 4)));
      chk($sformatf("vec%0d_imm", i),   64'(out_imm),   64'(tbl[i].imm));
      chk($sformatf("vec%0d_alu", i),   64'(out_alu_op), 64'(tbl[i].alu));
      chk($sformatf("vec%0d_ctrl", i),  64'(out_ctrl),  64'(tbl[i].ctrl));
      chk($sformatf("vec%0d_rd", i),    64'(out_rd),    64'(tbl[i].rd));
      chk($sformatf("vec%0d_nm_ctrl", i), 64'(nm_ctrl), 64'(tbl[i].ctrl_nm));
    end
    @(negedge clk);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Four back-to-back instructions, EXU stalled for three cycles
    seq_inst = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
    idx = 0;
    in_valid = 1'b1; out_ready = 1'b0; in_inst = seq_inst[0]; in_pc = 32'h100;
    for (int k = 0; k < 30 && got.size() < 4; k++) begin
      will_acc = in_valid && in_ready;
      will_pop = out_valid && out_ready;
      if (will_pop) got.push_back(out_pc);
      @(negedge clk);
      if (will_acc) begin
        idx++;
        if (idx < 4) begin in_inst = seq_inst[idx]; in_pc = 32'h100 + 32'(idx * 4); end
        else in_valid = 1'b0;
      end
      if (k + 1 == 2) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (k + 1 <= 3) begin
        chk("stall_out_pc",  64'(out_pc),   64'h100);
        chk("stall_out_imm", 64'(out_imm),  64'd1);
        chk("stall_valid",   64'(out_valid), 64'd1);
      end
      out_ready = (k + 1 >= 3);
    end
    chk("b2b_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_order%0d", i), 64'(i < got.size() ? got[i] : 32'hDEAD), 64'(32'h100 + 32'(i * 4)));
    in_valid = 1'b0;

    // Flush while full, with a new instruction presented
    idle_inputs();
    fill_two();
    chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0293; in_pc = 32'hF00;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h0060_0313; in_pc = 32'h200;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_pc",    64'(out_pc),    64'h200);
    @(negedge clk);
    chk("post_flush_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset while stalled and full
    idle_inputs();
    fill_two();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",    64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready),  64'd1);
    chk("async_rst_ctrl",     64'(out_ctrl),  64'd0);
    chk("async_rst_pc",       64'(out_pc),    64'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h0010_0073; in_pc = 32'h300;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ebreak_valid", 64'(out_valid), 64'd1);
    chk("ebreak_ctrl",  64'(out_ctrl),  64'h200);

    // Randomized traffic against the occupancy/FIFO model
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
      if (q.size() > 0) chk_bundle("rnd", q[0]);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_pc     = $urandom;
      if ($urandom_range(0, 1) == 1) in_inst = tbl[$urandom_range(0, 15)].inst;
      else begin
        in_inst = $urandom;
        if ($urandom_range(0, 3) != 0) in_inst[1:0] = 2'b11;
      end
      will_acc = in_valid && (q.size() < 2);
      will_pop = out_ready && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (will_pop) void'(q.pop_front());
        if (will_acc) begin
          e = ref_dec(in_inst);
          e.pc = in_pc;
          q.push_back(e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
